// File: rtl/axi_sram_write_slave_pkg.sv
// axi_sram_write_slave_pkg: AXI widths, response/burst codes, write FSM states and strobe-to-mask helper
package axi_sram_write_slave_pkg;
  localparam int AXI_ID_BITS    = 8;
  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_DATA_BITS  = 32;
  localparam int AXI_STRB_BITS  = 4;
  localparam int AXI_LEN_BITS   = 4;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;
  localparam int AXI_RESP_BITS  = 2;
  localparam logic [AXI_RESP_BITS-1:0]  BRESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_BITS-1:0]  BRESP_SLVERR = 2'b10;
  localparam logic [AXI_BURST_BITS-1:0] BURST_FIXED  = 2'b00;
  localparam logic [AXI_BURST_BITS-1:0] BURST_INCR   = 2'b01;
  localparam logic [AXI_BURST_BITS-1:0] BURST_WRAP   = 2'b10;
  localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD    = 3'b010;
  typedef enum logic [1:0] {INIT, IDLE, WDATA, BRESP} wr_state_e;
  function automatic logic [AXI_DATA_BITS-1:0] strb2bweb(input logic [AXI_STRB_BITS-1:0] strb);
    logic [AXI_DATA_BITS-1:0] m;
    for (int i = 0; i < AXI_STRB_BITS; i++) m[8*i+:8] = {8{~strb[i]}};
    return m;
  endfunction
endpackage

// File: rtl/axi_sram_write_slave_if.sv
// axi_sram_write_slave_if: AXI AW/W/B channel bundle; slave modport for the responder, master for the driver
interface axi_sram_write_slave_if;
  import axi_sram_write_slave_pkg::*;
  logic [AXI_ID_BITS-1:0]    awid;
  logic [AXI_ADDR_BITS-1:0]  awaddr;
  logic [AXI_LEN_BITS-1:0]   awlen;
  logic [AXI_SIZE_BITS-1:0]  awsize;
  logic [AXI_BURST_BITS-1:0] awburst;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_BITS-1:0]  wdata;
  logic [AXI_STRB_BITS-1:0]  wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [AXI_ID_BITS-1:0]    bid;
  logic [AXI_RESP_BITS-1:0]  bresp;
  logic                      bvalid;
  logic                      bready;
  modport slave(
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
  modport master(
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_write_slave.sv
// axi_sram_write_slave: single-outstanding AXI write responder driving a single-port SRAM
// Ports: clk, rst (async, active-low); axi (AW/W/B slave channels);
//        ceb_o/web_o (active-low SRAM enables), bweb_o (active-low bit mask), a_o (word address), di_o (write data)
module axi_sram_write_slave
  import axi_sram_write_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
  parameter int          SRAM_AW   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_sram_write_slave_if.slave    axi,
  output logic                     ceb_o,
  output logic                     web_o,
  output logic [AXI_DATA_BITS-1:0] bweb_o,
  output logic [SRAM_AW-1:0]       a_o,
  output logic [AXI_DATA_BITS-1:0] di_o
);
  wr_state_e                 state_q, state_d;
  logic [AXI_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [AXI_ID_BITS-1:0]    id_q, id_d;
  logic [AXI_LEN_BITS-1:0]   len_q, len_d;
  logic [AXI_BURST_BITS-1:0] burst_q, burst_d;
  logic [AXI_LEN_BITS:0]     cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic                      w_hs, over, wr_en;
  // subtract-then-compare so a window ending at 2^32 cannot overflow
  function automatic logic in_win(input logic [AXI_ADDR_BITS-1:0] a);
    return a >= ADDR_BASE && (a - ADDR_BASE) < ADDR_SIZE;
  endfunction
  assign axi.awready = state_q == IDLE;
  assign axi.wready  = state_q == WDATA;
  assign axi.bvalid  = state_q == BRESP;
  assign axi.bid     = axi.bvalid ? id_q : '0;
  assign axi.bresp   = axi.bvalid && err_q ? BRESP_SLVERR : BRESP_OKAY;
  assign w_hs  = axi.wvalid & axi.wready;
  assign over  = cnt_q > {1'b0, len_q};
  assign wr_en = w_hs & ~err_q & in_win(addr_q) & ~over;
  assign ceb_o  = ~wr_en;
  assign web_o  = ~wr_en;
  assign bweb_o = wr_en ? strb2bweb(axi.wstrb) : '1;
  assign a_o    = wr_en ? addr_q[SRAM_AW+1:2] : '0;
  assign di_o   = wr_en ? axi.wdata : '0;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: if (axi.awvalid) begin
        id_d    = axi.awid;
        addr_d  = axi.awaddr;
        len_d   = axi.awlen;
        burst_d = axi.awburst;
        cnt_d   = '0;
        err_d   = axi.awsize != SIZE_WORD || !in_win(axi.awaddr);
        state_d = WDATA;
      end
      WDATA: if (w_hs) begin
        // saturate so a long run of extra beats keeps reading as "past len"
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        addr_d  = burst_q == BURST_FIXED ? addr_q : addr_q + 32'd4;
        err_d   = err_q | ~in_win(addr_q) | over | (axi.wlast & (cnt_q != {1'b0, len_q}));
        state_d = axi.wlast ? BRESP : WDATA;
      end
      BRESP: if (axi.bready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_sram_write_slave.sv
// tb_axi_sram_write_slave: directed table, reset-abort sequence and randomized bursts against a transaction-level model
module tb_axi_sram_write_slave;
  import axi_sram_write_slave_pkg::*;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;
  localparam logic [127:0] RST_VEC = {1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ceb, web;
  logic [31:0] bweb, di;
  logic [13:0] a;
  int tests = 0;
  int fails = 0;
  int nwr = 0;
  logic [13:0] last_a;
  logic [31:0] last_bweb;
  logic [31:0] sram [int];
  logic [31:0] exp_mem [int];
  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;
    logic [3:0]  strb;
    int          bdly;
    logic [1:0]  exp_resp;
    int          exp_nw;
    logic [13:0] exp_a;
    logic [31:0] exp_bweb;
  } vec_t;
  vec_t v [9];
  axi_sram_write_slave_if ax();
  axi_sram_write_slave #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE), .SRAM_AW(14)) dut (
    .clk(clk), .rst(rst), .axi(ax),
    .ceb_o(ceb), .web_o(web), .bweb_o(bweb), .a_o(a), .di_o(di)
  );
  always #5 clk = ~clk;
  // SRAM behavioural model: active-low mask selects which bits take new data
  always @(posedge clk) begin
    if (!ceb && !web) begin
      sram[int'(a)] = ((sram.exists(int'(a)) ? sram[int'(a)] : 32'h0) & bweb) | (di & ~bweb);
      last_a = a;
      last_bweb = bweb;
      nwr++;
    end
  end
  function automatic logic [127:0] outs();
    return {ax.awready, ax.wready, ax.bvalid, ax.bid, ax.bresp, ceb, web, bweb, a, di};
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic bit in_win(input longint ad);
    return ad >= longint'(BASE) && ad < longint'(BASE) + longint'(SIZE);
  endfunction
  // transaction-level expectation: walk the beats, write each one that lands while the burst is still clean
  task automatic model(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input logic [31:0] d[$], input logic [3:0] s[$],
                       output logic [1:0] resp, output int nw);
    bit err;
    longint ad;
    int key;
    logic [31:0] w;
    err = size != 3'b010 || !in_win(longint'(addr));
    nw = 0;
    for (int i = 0; i < d.size(); i++) begin
      ad = burst == 2'b00 ? longint'(addr) : (longint'(addr) + 64'(4 * i)) % (64'd1 << 32);
      if (!err && in_win(ad) && i <= int'(len)) begin
        key = int'((ad >> 2) & 64'h3FFF);
        w = exp_mem.exists(key) ? exp_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[i][b]) w[8*b+:8] = d[i][8*b+:8];
        exp_mem[key] = w;
        nw++;
      end
      if (!in_win(ad) || i > int'(len) || (i == d.size() - 1 && i != int'(len))) err = 1;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask
  task automatic chk_mem(input string nm);
    bit ok;
    ok = sram.num() == exp_mem.num();
    foreach (exp_mem[k]) if (!sram.exists(k) || sram[k] !== exp_mem[k]) ok = 0;
    chk(nm, 128'(ok), 128'd1);
  endtask
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    ax.awid = id; ax.awaddr = addr; ax.awlen = len; ax.awsize = size; ax.awburst = burst;
    ax.awvalid = 1'b1;
    t = 0;
    while (ax.awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_wait", 128'(t < 50), 128'd1);
    @(posedge clk); #1;
    ax.awvalid = 1'b0;
  endtask
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input bit last);
    int t;
    ax.wvalid = 1'b1; ax.wdata = d; ax.wstrb = s; ax.wlast = last;
    t = 0;
    while (ax.wready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("w_wait", 128'(t < 50), 128'd1);
    @(posedge clk); #1;
  endtask
  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                         input logic [3:0] strb, input bit rand_strb, input int bdly,
                         output logic [1:0] resp_o, output int nw_o);
    logic [31:0] d[$];
    logic [3:0] s[$];
    logic [1:0] er;
    int enw, nw0, t;
    nw0 = nwr;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      d.push_back($urandom);
      s.push_back(rand_strb ? 4'($urandom) : strb);
      send_beat(d[i], s[i], i == nbeats - 1);
    end
    ax.wvalid = 1'b0; ax.wlast = 1'b0;
    model(addr, len, size, burst, d, s, er, enw);
    t = 0;
    while (ax.bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("b_wait", 128'(t < 50), 128'd1);
    for (int k = 0; k < bdly; k++) begin
      ax.awvalid = 1'b1;
      chk("b_hold", 128'({ax.bvalid, ax.bid, ax.bresp, ax.awready}), 128'({1'b1, id, er, 1'b0}));
      @(posedge clk); #1;
    end
    chk("b_resp", 128'({ax.bvalid, ax.bid, ax.bresp}), 128'({1'b1, id, er}));
    resp_o = ax.bresp;
    ax.bready = 1'b1;
    @(posedge clk); #1;
    ax.bready = 1'b0;
    chk("b_done", 128'({ax.bvalid, ax.awready}), 128'({1'b0, 1'b1}));
    ax.awvalid = 1'b0;
    nw_o = nwr - nw0;
    chk("n_writes", 128'(nw_o), 128'(enw));
    chk_mem("mem");
  endtask
  initial begin
    logic [1:0] r;
    int w;
    v[0] = '{8'h5A, BASE + 32'd8,  4'd0, 3'b010, 2'b01, 1, 4'hF, 5, 2'b00, 1, 14'd2,     32'h0000_0000};
    v[1] = '{8'h11, BASE,          4'd3, 3'b010, 2'b01, 4, 4'h3, 0, 2'b00, 4, 14'd3,     32'hFFFF_0000};
    v[2] = '{8'h22, BASE + 32'd4,  4'd2, 3'b010, 2'b00, 3, 4'hF, 1, 2'b00, 3, 14'd1,     32'h0000_0000};
    v[3] = '{8'h33, BASE + SIZE,   4'd0, 3'b010, 2'b01, 1, 4'hF, 0, 2'b10, 0, 14'd0,     32'h0};
    v[4] = '{8'h44, BASE,          4'd3, 3'b010, 2'b01, 2, 4'hF, 2, 2'b10, 2, 14'd1,     32'h0000_0000};
    v[5] = '{8'h55, BASE + 32'd16, 4'd0, 3'b011, 2'b01, 1, 4'hF, 0, 2'b10, 0, 14'd0,     32'h0};
    v[6] = '{8'h66, BASE + 32'd32, 4'd1, 3'b010, 2'b01, 3, 4'hF, 0, 2'b10, 2, 14'd9,     32'h0000_0000};
    v[7] = '{8'h77, BASE + SIZE - 32'd4, 4'd1, 3'b010, 2'b01, 2, 4'h5, 0, 2'b10, 1, 14'h3FFF, 32'hFF00_FF00};
    v[8] = '{8'h88, BASE + 32'd64, 4'd1, 3'b010, 2'b10, 2, 4'hF, 0, 2'b00, 2, 14'd17,    32'h0000_0000};
    ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0; ax.awburst = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), RST_VEC);
    rst = 1'b1;
    #1;
    chk("init_outs", outs(), RST_VEC);
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      run_txn(v[i].id, v[i].addr, v[i].len, v[i].size, v[i].burst, v[i].nbeats, v[i].strb, 0, v[i].bdly, r, w);
      chk($sformatf("vec%0d_resp", i), 128'(r), 128'(v[i].exp_resp));
      chk($sformatf("vec%0d_nw", i), 128'(w), 128'(v[i].exp_nw));
      if (v[i].exp_nw > 0) chk($sformatf("vec%0d_a_bweb", i), 128'({last_a, last_bweb}), 128'({v[i].exp_a, v[i].exp_bweb}));
    end
    begin
      logic [31:0] d[$];
      logic [3:0] s[$];
      int nw0, enw;
      nw0 = nwr;
      send_aw(8'h99, BASE + 32'd128, 4'd7, 3'b010, 2'b01);
      for (int i = 0; i < 3; i++) begin
        d.push_back($urandom);
        s.push_back(4'hF);
        send_beat(d[i], s[i], 1'b0);
      end
      ax.wvalid = 1'b1; ax.wdata = 32'hBAD0_BAD0;
      #2 rst = 1'b0;
      #1 chk("rst_mid_outs", outs(), RST_VEC);
      @(posedge clk); #1;
      chk("rst_hold_outs", outs(), RST_VEC);
      ax.wvalid = 1'b0;
      rst = 1'b1;
      #1 chk("rst_init_outs", outs(), RST_VEC);
      @(posedge clk); #1;
      chk("rst_idle", 128'({ax.awready, ax.bvalid}), 128'({1'b1, 1'b0}));
      model(BASE + 32'd128, 4'd7, 3'b010, 2'b01, d, s, r, enw);
      chk("rst_nw", 128'(nwr - nw0), 128'(enw));
      chk_mem("rst_mem");
      run_txn(8'hA1, BASE + 32'd256, 4'd2, 3'b010, 2'b01, 3, 4'hF, 0, 1, r, w);
      chk("after_rst_resp", 128'(r), 128'd0);
    end
    for (int n = 0; n < 25; n++) begin
      logic [31:0] ad;
      logic [3:0] len;
      int sel, nb;
      sel = int'($urandom_range(0, 9));
      ad = sel == 0 ? BASE + SIZE - 32'(4 * $urandom_range(0, 2)) :
           sel == 1 ? 32'hFFFF_FFFC :
           sel == 2 ? BASE - 32'd4 : BASE + 32'(4 * $urandom_range(0, 16383));
      len = 4'($urandom_range(0, 15));
      nb = $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 18)) : int'(len) + 1;
      run_txn(8'($urandom), ad, len, $urandom_range(0, 7) == 0 ? 3'b001 : 3'b010,
              2'($urandom_range(0, 2)), nb, 4'hF, 1, int'($urandom_range(0, 3)), r, w);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
